mc_mips_core: RTL and testbench
===============================

Name: mc_mips_core

Overview:
- Multi-cycle successor to the single-cycle MIPS datapath.
- Shares one memory port across instruction fetch and load/store. The port uses a variable-latency req/ready handshake.
- Each instruction is sequenced through a control FSM. Register file and ALU are internal; memory is external.
- PC width and reset vector are parametrised. Adds trap/halt on illegal or misaligned operations and a retire pulse for bench tracking.

Parameters:
- ADDR_WIDTH, 32, width of PC and mem_addr; 8..32 allowed, upper PC bits truncated.
- RESET_PC, 0, PC value loaded on reset; must be word-aligned.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- mem_req  output  1  memory transaction request
- mem_we  output  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  output  ADDR_WIDTH  byte address, always word-aligned while mem_req=1
- mem_wdata  output  32  store data
- mem_rdata  input  32  read data, sampled when mem_req & mem_ready
- mem_ready  input  1  completes the current transaction in the same cycle
- retire  output  1  one-cycle pulse when an instruction completes
- halt  output  1  sticky trap indicator
- pc_out  output  ADDR_WIDTH  current PC

Behaviour:
- Reset:
  - Effect at the clock edge: state=FETCH, PC=RESET_PC, IR/A/B/ALUOut/MDR=0, all 32 registers=0.
  - Outputs during any cycle rst=1: mem_req=0, retire=0, halt=0.
  - Reset mid-transaction abandons the transaction; no register or PC update from it.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until the cycle mem_ready=1.
  - mem_ready is ignored when mem_req=0.
  - Zero-wait memory (ready same cycle) is supported.
- FETCH:
  - Drives mem_req=1, mem_we=0, mem_addr=PC.
  - On ready: IR<=mem_rdata, PC<=PC+4 (wraps mod 2^ADDR_WIDTH), go to DECODE.
- DECODE:
  - A<=R[rs], B<=R[rt].
  - ALUOut<=PC+(sext(imm16)<<2), i.e. the branch target.
  - Go to EXEC.
- EXEC, by opcode:
  - R-type (000000), then WB. ALUOut<=A op B; funct add 100000, sub 100010, and 100100, or 100101, slt 101010. slt is a signed compare, result 1/0.
  - addi (001000): ALUOut<=A+sext(imm), then WB.
  - lw (100011) / sw (101011): ALUOut<=A+sext(imm). If the sum's bits[1:0]≠0, go to TRAP; otherwise go to MEM.
  - beq (000100): if A==B, PC<=ALUOut. retire=1, then FETCH.
  - j (000010): PC<={PC[ADDR_WIDTH-1:28], imm26, 2'b00} when ADDR_WIDTH>28, else low ADDR_WIDTH bits of {imm26,2'b00}. retire=1, then FETCH.
  - Any other opcode or funct: go to TRAP.
  - Arithmetic is 32-bit wrap-around; no overflow exceptions.
- MEM:
  - Drives mem_req=1, mem_addr=ALUOut[ADDR_WIDTH-1:0].
  - lw: mem_we=0; on ready MDR<=mem_rdata, then WB.
  - sw: mem_we=1, mem_wdata=B; on ready retire=1, then FETCH.
- WB:
  - Writes ALUOut to rd for R-type, ALUOut to rt for addi, MDR to rt for lw.
  - Writes to R0 are discarded; R0 always reads 0.
  - retire=1, then FETCH.
- TRAP:
  - halt=1, mem_req=0.
  - PC holds the address of the faulting instruction + 4.
  - Remains in TRAP until rst.
- Latency with zero-wait memory:
  - R-type/addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/j: 3 cycles.
  - Each memory wait cycle adds 1.
- retire is registered, asserted exactly once per completed instruction, and never asserted in TRAP.

Test Plan:
- Reset with RESET_PC=0x100 → first mem_req cycle after rst drops shows mem_addr=0x100, mem_we=0, halt=0.
- Program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0($0), zero-wait memory → word 0 written with 12; retire pulses 4 times; store issued on cycle 15 after reset.
- lw with mem_ready delayed 3 cycles → mem_addr/mem_we stable for all 4 request cycles; loaded value appears in rt; total lw cycles = 8.
- beq $1,$1,-1 → PC loops to the same address; beq $1,$2 with unequal values → falls through to PC+4. j 0x40 → next fetch at 0x100.
- Illegal opcode 0x3F, or lw at address 0x2 → halt=1, no further mem_req, retire stays 0. After rst, execution restarts at RESET_PC.
- addi $0,$0,9 then add $4,$0,$0 → $4=0; slt with −1 vs 1 gives 1. rst asserted mid-FETCH wait → transaction abandoned, PC=RESET_PC.

Source files
------------

// File: rtl/mc_mips_core.sv
// Multi-cycle MIPS subset core: one req/ready memory port shared by fetch and load/store,
// FSM-sequenced datapath, sticky trap on illegal or misaligned operations.
module mc_mips_core #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic                  retire,
  output logic                  halt,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [31:0]           ir;
  logic [31:0]           a;
  logic [31:0]           b;
  logic [31:0]           alu_out;
  logic [31:0]           mdr;
  logic [31:0]           regs [32];
  logic                  retire_q;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] sext_imm;
  logic [31:0] pc_ext;
  logic [31:0] jump_target;
  logic [31:0] addr_sum;
  logic [31:0] r_res;
  logic        r_ok;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  assign opcode      = ir[31:26];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign rd          = ir[15:11];
  assign funct       = ir[5:0];
  assign sext_imm    = {{16{ir[15]}}, ir[15:0]};
  assign pc_ext      = 32'(pc);
  // Upper PC bits above ADDR_WIDTH are zero in pc_ext and fall away on truncation.
  assign jump_target = {pc_ext[31:28], ir[25:0], 2'b00};
  assign addr_sum    = a + sext_imm;

  always_comb begin
    r_ok  = 1'b1;
    r_res = '0;
    case (funct)
      FN_ADD:  r_res = a + b;
      FN_SUB:  r_res = a - b;
      FN_AND:  r_res = a & b;
      FN_OR:   r_res = a | b;
      FN_SLT:  r_res = {31'b0, ($signed(a) < $signed(b))};
      default: r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    wb_addr = rt;
    wb_data = alu_out;
    if (opcode == OP_RTYPE) begin
      wb_addr = rd;
    end else if (opcode == OP_LW) begin
      wb_data = mdr;
    end
  end

  // Port signals decode only registered state, so they stay stable through wait cycles.
  assign mem_req   = !rst && ((state == S_FETCH) || (state == S_MEM));
  assign mem_we    = (state == S_MEM) && (opcode == OP_SW);
  assign mem_addr  = (state == S_MEM) ? alu_out[ADDR_WIDTH-1:0] : pc;
  assign mem_wdata = b;
  assign retire    = retire_q && !rst;
  assign halt      = !rst && (state == S_TRAP);
  assign pc_out    = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= RESET_PC[ADDR_WIDTH-1:0];
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      alu_out  <= '0;
      mdr      <= '0;
      retire_q <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else begin
      retire_q <= 1'b0;
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            pc    <= pc + ADDR_WIDTH'(4);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a       <= regs[rs];
          b       <= regs[rt];
          alu_out <= pc_ext + {sext_imm[29:0], 2'b00};
          state   <= S_EXEC;
        end
        S_EXEC: begin
          case (opcode)
            OP_RTYPE: begin
              if (r_ok) begin
                alu_out <= r_res;
                state   <= S_WB;
              end else begin
                state <= S_TRAP;
              end
            end
            OP_ADDI: begin
              alu_out <= addr_sum;
              state   <= S_WB;
            end
            OP_LW, OP_SW: begin
              alu_out <= addr_sum;
              state   <= (addr_sum[1:0] != 2'b00) ? S_TRAP : S_MEM;
            end
            OP_BEQ: begin
              if (a == b) begin
                pc <= alu_out[ADDR_WIDTH-1:0];
              end
              retire_q <= 1'b1;
              state    <= S_FETCH;
            end
            OP_J: begin
              pc       <= jump_target[ADDR_WIDTH-1:0];
              retire_q <= 1'b1;
              state    <= S_FETCH;
            end
            default: state <= S_TRAP;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (opcode == OP_LW) begin
              mdr   <= mem_rdata;
              state <= S_WB;
            end else begin
              retire_q <= 1'b1;
              state    <= S_FETCH;
            end
          end
        end
        S_WB: begin
          if (wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
          end
          retire_q <= 1'b1;
          state    <= S_FETCH;
        end
        S_TRAP:  state <= S_TRAP;
        default: state <= S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_mips_core.sv
// Bench for mc_mips_core: word memory with programmable wait states, directed programs
// and random ALU programs checked against an instruction-level model.
module tb_mc_mips_core;
  localparam int          AW  = 32;
  localparam logic [31:0] RPC = 32'h100;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req, mem_we, mem_ready, retire, halt;
  logic [AW-1:0] mem_addr, pc_out;
  logic [31:0]   mem_wdata, mem_rdata;

  mc_mips_core #(.ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .halt(halt), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  logic [31:0] prog [$];
  int tests = 0;
  int fails = 0;

  int fetch_wait = 0;
  int data_wait  = 0;
  int rand_max   = 0;
  bit rand_mode  = 1'b0;
  logic [31:0] slow_addr = 32'hFFFF_FFFF;

  int cyc = 0;
  int wcnt = 0;
  int target = 0;
  int req_in_halt = 0;
  int retire_cyc [$];
  int store_cyc [$];
  int data_we [$];
  logic [31:0] fetch_addr [$];
  logic [31:0] data_addr [$];

  // Memory responder and event logger; addresses below 0x100 are data, the rest program.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0;
        wcnt = 0;
        mem_ready = 1'b0;
      end else begin
        if (retire) retire_cyc.push_back(cyc);
        if (mem_req) begin
          if (halt) req_in_halt++;
          if (mem_addr < 32'h100) begin
            data_addr.push_back(mem_addr);
            data_we.push_back(int'(mem_we));
          end
          if (wcnt == 0) begin
            if (rand_mode) target = int'($urandom_range(0, rand_max));
            else if (mem_addr == slow_addr) target = 10;
            else target = (mem_addr < 32'h100) ? data_wait : fetch_wait;
          end
          if (wcnt >= target) begin
            mem_ready = 1'b1;
            wcnt = 0;
            if (mem_we) begin
              mem[mem_addr[11:2]] = mem_wdata;
              store_cyc.push_back(cyc);
            end else begin
              mem_rdata = mem[mem_addr[11:2]];
              if (mem_addr >= 32'h100) fetch_addr.push_back(mem_addr);
            end
          end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            wcnt++;
          end
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
          mem_rdata = $urandom;
          wcnt = 0;
        end
        cyc++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rs, input int rt,
                                        input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] target26);
    return {OP_J, target26};
  endfunction

  function automatic logic [31:0] qf(input int i);
    return (i < fetch_addr.size()) ? fetch_addr[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic int qr(input int i);
    return (i < retire_cyc.size()) ? retire_cyc[i] : -1;
  endfunction

  function automatic int qs(input int i);
    return (i < store_cyc.size()) ? store_cyc[i] : -1;
  endfunction

  task automatic load_prog(input logic [31:0] fill);
    for (int i = 0; i < 1024; i++) mem[i] = fill;
    foreach (prog[i]) mem[64 + i] = prog[i];
  endtask

  task automatic do_reset(input bit chk);
    tick();
    rst = 1'b1;
    if (chk) begin
      @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_retire", 32'(retire), 32'd0);
      check("rst_halt", 32'(halt), 32'd0);
    end
    tick();
    tick();
    retire_cyc.delete();
    store_cyc.delete();
    fetch_addr.delete();
    data_addr.delete();
    data_we.delete();
    req_in_halt = 0;
    rst = 1'b0;
    @(negedge clk);
    if (chk) begin
      check("first_req", 32'(mem_req), 32'd1);
      check("first_addr", mem_addr, RPC);
      check("first_we", 32'(mem_we), 32'd0);
      check("first_halt", 32'(halt), 32'd0);
      check("first_pc", pc_out, RPC);
    end
  endtask

  task automatic run_to_halt(input int budget, input string tag);
    int n = 0;
    while (!halt && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_halted"}, 32'(halt), 32'd1);
  endtask

  initial begin
    logic [31:0] mr [32];
    logic [31:0] va, vb, res;
    logic [15:0] imm;
    int n, kind, rs, rt, rd;

    // Test-plan program, zero-wait, ending on an illegal opcode 0x3F
    prog.delete();
    prog.push_back(enc_i(OP_ADDI, 0, 1, 16'd5));
    prog.push_back(enc_i(OP_ADDI, 0, 2, 16'd7));
    prog.push_back(enc_r(FN_ADD, 1, 2, 3));
    prog.push_back(enc_i(OP_SW, 0, 3, 16'd0));
    prog.push_back(ILLEGAL);
    load_prog(32'hFFFF_FFFF);
    do_reset(1'b1);
    run_to_halt(200, "p1");
    check("p1_mem0", mem[0], 32'd12);
    check("p1_store_cycle", 32'(qs(0)), 32'd15);
    check("p1_retire_count", 32'(retire_cyc.size()), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("p1_retire_cyc%0d", i), 32'(qr(i)), 32'(4 * (i + 1)));
    check("p1_trap_pc", pc_out, 32'h114);
    run(10);
    check("p1_req_in_halt", 32'(req_in_halt), 32'd0);
    check("p1_retire_after_halt", 32'(retire_cyc.size()), 32'd4);

    // Load with three data wait states
    prog.delete();
    prog.push_back(enc_i(OP_LW, 0, 5, 16'd8));
    prog.push_back(enc_i(OP_SW, 0, 5, 16'd4));
    prog.push_back(ILLEGAL);
    load_prog(32'h0);
    mem[2] = 32'hDEAD_BEEF;
    data_wait = 3;
    do_reset(1'b0);
    run_to_halt(200, "lw");
    n = 0;
    while (n < data_addr.size() && data_addr[n] == 32'h8 && data_we[n] == 0) n++;
    check("lw_stable_req_cycles", 32'(n), 32'd4);
    check("lw_retire_cycle", 32'(qr(0)), 32'd8);
    check("lw_sw_retire_cycle", 32'(qr(1)), 32'd15);
    check("lw_value_stored", mem[1], 32'hDEAD_BEEF);
    data_wait = 0;

    // beq to itself
    prog.delete();
    prog.push_back(enc_i(OP_ADDI, 0, 1, 16'd3));
    prog.push_back(enc_i(OP_BEQ, 1, 1, 16'hFFFF));
    load_prog(32'h0);
    do_reset(1'b0);
    run(20);
    check("beq_loop_f0", qf(0), 32'h100);
    for (int i = 1; i < 4; i++) check($sformatf("beq_loop_f%0d", i), qf(i), 32'h104);
    check("beq_loop_retire", 32'(qr(2)), 32'd10);
    check("beq_loop_nohalt", 32'(halt), 32'd0);

    // beq not taken, then j 0x40 back to 0x100
    prog.delete();
    prog.push_back(enc_i(OP_ADDI, 0, 1, 16'd1));
    prog.push_back(enc_i(OP_ADDI, 0, 2, 16'd2));
    prog.push_back(enc_i(OP_BEQ, 1, 2, 16'd5));
    prog.push_back(enc_j(26'h40));
    load_prog(32'h0);
    do_reset(1'b0);
    run(30);
    for (int i = 0; i < 6; i++)
      check($sformatf("bj_fetch%0d", i), qf(i), 32'h100 + 32'(4 * (i % 4)));

    // Misaligned load traps
    prog.delete();
    prog.push_back(enc_i(OP_LW, 0, 1, 16'd2));
    load_prog(32'h0);
    do_reset(1'b0);
    run_to_halt(50, "mis");
    check("mis_retires", 32'(retire_cyc.size()), 32'd0);
    check("mis_pc", pc_out, 32'h104);
    run(10);
    check("mis_req_in_halt", 32'(req_in_halt), 32'd0);
    check("mis_data_reqs", 32'(data_addr.size()), 32'd0);

    // Unsupported R-type funct traps
    prog.delete();
    prog.push_back(enc_r(6'h21, 1, 2, 3));
    load_prog(32'h0);
    do_reset(1'b0);
    run_to_halt(50, "badfn");
    check("badfn_retires", 32'(retire_cyc.size()), 32'd0);

    // R0 discard and signed slt; reset is entered from the halted state
    prog.delete();
    prog.push_back(enc_i(OP_ADDI, 0, 0, 16'd9));
    prog.push_back(enc_r(FN_ADD, 0, 0, 4));
    prog.push_back(enc_i(OP_SW, 0, 4, 16'd0));
    prog.push_back(enc_i(OP_ADDI, 0, 5, 16'hFFFF));
    prog.push_back(enc_i(OP_ADDI, 0, 6, 16'd1));
    prog.push_back(enc_r(FN_SLT, 5, 6, 7));
    prog.push_back(enc_i(OP_SW, 0, 7, 16'd4));
    prog.push_back(enc_r(FN_SLT, 6, 5, 8));
    prog.push_back(enc_i(OP_SW, 0, 8, 16'd8));
    prog.push_back(ILLEGAL);
    load_prog(32'hFFFF_FFFF);
    do_reset(1'b1);
    run_to_halt(300, "r0");
    check("r0_add_zero", mem[0], 32'd0);
    check("slt_neg_lt_pos", mem[1], 32'd1);
    check("slt_pos_lt_neg", mem[2], 32'd0);

    // Reset during a stalled fetch of the second instruction
    prog.delete();
    prog.push_back(enc_i(OP_ADDI, 0, 1, 16'd5));
    prog.push_back(enc_i(OP_SW, 0, 1, 16'd0));
    prog.push_back(ILLEGAL);
    load_prog(32'h0);
    slow_addr = 32'h104;
    do_reset(1'b0);
    run(6);
    check("abort_mid_pc", pc_out, 32'h104);
    check("abort_mid_req", 32'(mem_req), 32'd1);
    slow_addr = 32'hFFFF_FFFF;
    do_reset(1'b1);
    run_to_halt(100, "abort");
    check("abort_restart_fetch", qf(0), RPC);
    check("abort_result", mem[0], 32'd5);

    // Random ALU programs with random wait states against the instruction-level model
    for (int t = 0; t < 3; t++) begin
      rand_mode = 1'b1;
      rand_max = t;
      prog.delete();
      for (int r = 0; r < 32; r++) mr[r] = '0;
      for (int k = 0; k < 20; k++) begin
        kind = int'($urandom_range(0, 5));
        rs = int'($urandom_range(0, 7));
        rt = int'($urandom_range(0, 7));
        rd = int'($urandom_range(0, 7));
        va = mr[rs];
        vb = mr[rt];
        if (kind == 0) begin
          imm = 16'($urandom);
          prog.push_back(enc_i(OP_ADDI, rs, rt, imm));
          res = va + {{16{imm[15]}}, imm};
          if (rt != 0) mr[rt] = res;
        end else begin
          case (kind)
            1: begin prog.push_back(enc_r(FN_ADD, rs, rt, rd)); res = va + vb; end
            2: begin prog.push_back(enc_r(FN_SUB, rs, rt, rd)); res = va - vb; end
            3: begin prog.push_back(enc_r(FN_AND, rs, rt, rd)); res = va & vb; end
            4: begin prog.push_back(enc_r(FN_OR, rs, rt, rd)); res = va | vb; end
            default: begin
              prog.push_back(enc_r(FN_SLT, rs, rt, rd));
              res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
            end
          endcase
          if (rd != 0) mr[rd] = res;
        end
      end
      for (int r = 1; r < 8; r++) prog.push_back(enc_i(OP_SW, 0, r, 16'(4 * r)));
      prog.push_back(ILLEGAL);
      load_prog(32'h0);
      do_reset(1'b0);
      run_to_halt(3000, "rand");
      for (int r = 1; r < 8; r++) check($sformatf("rand%0d_reg%0d", t, r), mem[r], mr[r]);
      check($sformatf("rand%0d_retires", t), 32'(retire_cyc.size()), 32'd27);
    end
    rand_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
